host_uart_cmd_assembler: RTL and testbench

//  Upstream stage of the host RX pipeline. Collects raw bytes from the UART receiver into a
//  128-byte command frame. On the terminator byte it presents the frame, pulses the launch

---
 rtl/host_cmd_pkg.sv | 17 +
 rtl/cmd_idle_timer.sv | 22 ++
 rtl/host_uart_cmd_assembler.sv | 121 ++++++++++++
 tb/tb_host_uart_cmd_assembler.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/host_cmd_pkg.sv
// host_cmd_pkg: shared command-frame constants and assembler state encodings
package host_cmd_pkg;
   localparam int         CMD_FRAME_BYTES = 128;
   localparam logic [7:0] CMD_TERM_BYTE   = 8'h0D;
   localparam logic [2:0] ST_COLLECT   = 3'd0;
   localparam logic [2:0] ST_DISCARD   = 3'd1;
   localparam logic [2:0] ST_LAUNCH    = 3'd2;
   localparam logic [2:0] ST_WAIT_LOW  = 3'd3;
   localparam logic [2:0] ST_WAIT_HIGH = 3'd4;
   typedef enum logic [2:0] {
      COLLECT   = ST_COLLECT,
      DISCARD   = ST_DISCARD,
      LAUNCH    = ST_LAUNCH,
      WAIT_LOW  = ST_WAIT_LOW,
      WAIT_HIGH = ST_WAIT_HIGH
   } cmd_state_e;
endpackage

// File: rtl/cmd_idle_timer.sv
// cmd_idle_timer: idle-cycle counter for partial frames, built only with CMD_ASM_TIMEOUT_EN
`ifdef CMD_ASM_TIMEOUT_EN
module cmd_idle_timer #(
   parameter int CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int W = $clog2(CYCLES + 1);
   logic [W-1:0] cnt_q, cnt_d;
   assign expired = cnt_q == W'(CYCLES);
   // count enabled idle cycles, saturating at the limit
   always_comb cnt_d = clear ? '0 : (enable && !expired) ? cnt_q + 1'b1 : cnt_q;
   // counter register
   always_ff @(posedge clk or posedge reset)
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
endmodule
`endif

// File: rtl/host_uart_cmd_assembler.sv
// host_uart_cmd_assembler: assembles UART bytes into a command frame and hands it downstream
module host_uart_cmd_assembler
  import host_cmd_pkg::*;
#(
  parameter int         MAX_BYTES      = CMD_FRAME_BYTES,
  parameter logic [7:0] TERM_BYTE      = CMD_TERM_BYTE,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_byte,
  input  logic                   rx_valid,
  input  logic                   pipe_done,
  input  logic                   pipe_error,
  output logic [8*MAX_BYTES-1:0] packet_data,
  output logic                   send_packet,
  output logic [7:0]             byte_count,
  output logic                   busy,
  output logic                   overflow_err,
  output logic                   overrun_err,
  output logic                   cmd_err,
  output logic                   timeout_err
);
  localparam int FW = 8 * MAX_BYTES;
  localparam int AW = $clog2(FW);
  cmd_state_e    state_q, state_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [7:0]    count_q, count_d;
  logic          ovf_q, ovf_d, ovr_q, ovr_d, cmd_q, cmd_d, to_q, to_d;
  logic [AW-1:0] wr_lsb;
  logic          to_hit;
  assign wr_lsb       = AW'((MAX_BYTES - 1 - int'(count_q)) * 8);
  assign packet_data  = frame_q;
  assign byte_count   = count_q;
  assign send_packet  = state_q == LAUNCH;
  assign busy         = state_q == LAUNCH || state_q == WAIT_LOW || state_q == WAIT_HIGH;
  assign overflow_err = ovf_q;
  assign overrun_err  = ovr_q;
  assign cmd_err      = cmd_q;
  assign timeout_err  = to_q;
`ifdef CMD_ASM_TIMEOUT_EN
  logic idle_en;
  assign idle_en = state_q == COLLECT && count_q != 8'd0;
  cmd_idle_timer #(.CYCLES(TIMEOUT_CYCLES)) u_idle_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (rx_valid || !idle_en),
    .enable  (idle_en),
    .expired (to_hit)
  );
`else
  assign to_hit = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    ovr_d   = ovr_q;
    cmd_d   = cmd_q;
    to_d    = to_q;
    case (state_q)
      COLLECT:
        if (rx_valid) begin
          if (rx_byte == TERM_BYTE) begin
            if (count_q != 8'd0) state_d = LAUNCH;
          end else if (count_q == 8'(MAX_BYTES)) begin
            ovf_d   = 1'b1;
            frame_d = '0;
            count_d = '0;
            state_d = DISCARD;
          end else begin
            frame_d[wr_lsb +: 8] = rx_byte;
            count_d = count_q + 8'd1;
          end
        end else if (to_hit) begin
          frame_d = '0;
          count_d = '0;
          to_d    = 1'b1;
        end
      DISCARD:
        if (rx_valid && rx_byte == TERM_BYTE) state_d = COLLECT;
      LAUNCH: begin
        ovf_d   = 1'b0;
        ovr_d   = 1'b0;
        cmd_d   = 1'b0;
        to_d    = 1'b0;
        state_d = WAIT_LOW;
      end
      WAIT_LOW:
        if (!pipe_done) state_d = WAIT_HIGH;
      WAIT_HIGH:
        if (pipe_done) begin
          cmd_d   = pipe_error;
          frame_d = '0;
          count_d = '0;
          state_d = COLLECT;
        end
      default: state_d = COLLECT;
    endcase
    if (busy && rx_valid) ovr_d = 1'b1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= COLLECT;
      frame_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      ovr_q   <= 1'b0;
      cmd_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      ovr_q   <= ovr_d;
      cmd_q   <= cmd_d;
      to_q    <= to_d;
    end
endmodule

// File: tb/tb_host_uart_cmd_assembler.sv
// tb_host_uart_cmd_assembler: scoreboard bench for the UART command assembler
module tb_host_uart_cmd_assembler;
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    rx_byte = 8'h00;
  logic          rx_valid = 1'b0;
  logic          pipe_done = 1'b1;
  logic          pipe_error = 1'b0;
  logic [1023:0] packet_data;
  logic          send_packet;
  logic [7:0]    byte_count;
  logic          busy, overflow_err, overrun_err, cmd_err, timeout_err;
  int            checks = 0;
  int            errors = 0;
  logic [1023:0] q_data[$];
  int            q_cnt[$];
  logic [1023:0] exp_pkt;
  int            exp_n;
  logic          sp_prev = 1'b0;
  host_uart_cmd_assembler #(.TIMEOUT_CYCLES(50)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_byte      (rx_byte),
    .rx_valid     (rx_valid),
    .pipe_done    (pipe_done),
    .pipe_error   (pipe_error),
    .packet_data  (packet_data),
    .send_packet  (send_packet),
    .byte_count   (byte_count),
    .busy         (busy),
    .overflow_err (overflow_err),
    .overrun_err  (overrun_err),
    .cmd_err      (cmd_err),
    .timeout_err  (timeout_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic rx(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask
  task automatic clr_exp();
    exp_pkt = '0;
    exp_n   = 0;
  endtask
  task automatic add(input logic [7:0] b);
    rx(b);
    exp_pkt[1023-8*exp_n -: 8] = b;
    exp_n++;
  endtask
  task automatic term();
    q_data.push_back(exp_pkt);
    q_cnt.push_back(exp_n);
    rx(8'h0D);
  endtask
  task automatic complete(input int n, input logic err);
    pipe_error = err;
    pipe_done  = 1'b0;
    repeat (n) @(negedge clk);
    pipe_done = 1'b1;
    @(negedge clk);
    pipe_error = 1'b0;
  endtask
  always @(negedge clk) begin
    if (!reset && send_packet) begin
      checks++;
      if (sp_prev) begin
        errors++;
        $display("FAIL send_pulse: send_packet high two cycles in a row");
      end else if (q_data.size() == 0) begin
        errors++;
        $display("FAIL unexpected_launch: byte_count=%0d packet=%h", byte_count, packet_data);
      end else begin
        logic [1023:0] d;
        int c;
        d = q_data.pop_front();
        c = q_cnt.pop_front();
        if (packet_data !== d) begin
          errors++;
          $display("FAIL launch_data: got %h expected %h", packet_data, d);
        end
        checks++;
        if (byte_count !== 8'(c)) begin
          errors++;
          $display("FAIL launch_count: got %0d expected %0d", byte_count, c);
        end
      end
    end
    sp_prev <= send_packet && !reset;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("reset_count", 32'(byte_count), 0);
    chk("reset_flags", {26'd0, send_packet, busy, overflow_err, overrun_err, cmd_err, timeout_err}, 0);
    chk("reset_data", 32'(packet_data != '0), 0);
    reset = 1'b0;
    @(negedge clk);
    clr_exp();
    add(8'h01); add(8'h02); add(8'h03);
    chk("t1_count", 32'(byte_count), 3);
    term();
    chk("t1_busy", 32'(busy), 1);
    complete(3, 1'b0);
    chk("t1_done_busy", 32'(busy), 0);
    chk("t1_done_count", 32'(byte_count), 0);
    rx(8'h0D);
    repeat (3) @(negedge clk);
    chk("t2_busy", 32'(busy), 0);
    chk("t2_count", 32'(byte_count), 0);
    clr_exp();
    for (int i = 0; i < 128; i++) add(8'hAA);
    chk("t3_full_count", 32'(byte_count), 128);
    chk("t3_full_ovf", 32'(overflow_err), 0);
    term();
    complete(3, 1'b0);
    for (int i = 0; i < 129; i++) rx(8'h11);
    chk("t3_ovf", 32'(overflow_err), 1);
    chk("t3_ovf_count", 32'(byte_count), 0);
    rx(8'h22);
    rx(8'h0D);
    repeat (2) @(negedge clk);
    chk("t3_disc_busy", 32'(busy), 0);
    chk("t3_disc_count", 32'(byte_count), 0);
    clr_exp();
    add(8'h05);
    term();
    @(negedge clk);
    chk("t3_ovf_cleared", 32'(overflow_err), 0);
    complete(2, 1'b0);
    clr_exp();
    add(8'h07);
    term();
    @(negedge clk);
    rx(8'h55);
    rx(8'h0D);
    chk("t4_overrun", 32'(overrun_err), 1);
    chk("t4_hold_count", 32'(byte_count), 1);
    complete(2, 1'b0);
    chk("t4_clr_count", 32'(byte_count), 0);
    chk("t4_clr_data", 32'(packet_data != '0), 0);
    chk("t4_sticky", 32'(overrun_err), 1);
    clr_exp();
    add(8'h09);
    term();
    @(negedge clk);
    chk("t5_ovr_cleared", 32'(overrun_err), 0);
    complete(20, 1'b1);
    chk("t5_cmd_err", 32'(cmd_err), 1);
    chk("t5_busy", 32'(busy), 0);
    clr_exp();
    add(8'h0A);
    term();
    @(negedge clk);
    chk("t5_cmd_cleared", 32'(cmd_err), 0);
    pipe_done = 1'b0;
    repeat (2) @(negedge clk);
    pipe_done = 1'b1;
    rx(8'h66);
    chk("t5_exit_busy", 32'(busy), 0);
    chk("t5_exit_count", 32'(byte_count), 0);
    chk("t5_exit_ovr", 32'(overrun_err), 1);
    @(negedge clk);
    chk("t5_exit_data", 32'(packet_data != '0), 0);
`ifdef CMD_ASM_TIMEOUT_EN
    rx(8'h01);
    repeat (55) @(negedge clk);
    chk("t6_timeout", 32'(timeout_err), 1);
    chk("t6_to_count", 32'(byte_count), 0);
`endif
    clr_exp();
    add(8'h02);
    term();
    pipe_done = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_flags", {26'd0, send_packet, busy, overflow_err, overrun_err, cmd_err, timeout_err}, 0);
    chk("t6_rst_count", 32'(byte_count), 0);
    chk("t6_rst_data", 32'(packet_data != '0), 0);
    @(negedge clk);
    reset = 1'b0;
    pipe_done = 1'b1;
    @(negedge clk);
    clr_exp();
    add(8'h03);
    term();
    complete(2, 1'b0);
    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(q_data.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
